// File: rtl/ms_serial_pkg.sv
// Shared definitions for the multi-sample serial link (transmit and receive sides).
// Holds the transmitter state encoding and the line-level constants.
package ms_serial_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/baud_tick_counter.sv
// Loadable bit-period down-counter. The tick output is registered and is high
// exactly while the count sits at 0, i.e. during the last clock of a bit period.
module baud_tick_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_tick,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic         r_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (i_load) begin
      r_count <= i_load_val;
      r_tick  <= (i_load_val == '0);
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
      r_tick  <= (r_count == W'(1));
    end
  end

  assign o_tick  = r_tick;
  assign o_count = r_count;

endmodule

// File: rtl/multi_sample_transmitter.sv
// Asynchronous frame serialiser: start bit, LSB-first data, optional parity,
// one or two stop bits. Frame settings are latched when a word is accepted.
module multi_sample_transmitter
  import ms_serial_pkg::*;
#(
  parameter int BAUD_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_busy,
  output logic                  txd,
  input  logic [BAUD_WIDTH-1:0] clk_per_baud,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  stop_2,
  output tx_state_t             dbg_state
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);

  tx_state_t             r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic [BCW-1:0]        r_bit_cnt, w_bit_cnt_nxt, w_stop_n;
  logic [BAUD_WIDTH-1:0] r_nm1, w_in_nm1, w_load_val, w_count;
  logic                  r_par_en, r_parity, r_stop2;
  logic                  r_txd, r_ready, r_busy;
  logic                  w_tick, w_accept, w_adv, w_txd_nxt, w_tick_nxt, w_ready_nxt;

  // Handshake: a word transfers on a rising edge where tx_valid and tx_ready are
  // both high. tx_ready is registered, so it never depends on tx_valid.
  assign w_accept   = tx_valid && r_ready;
  assign w_adv      = (r_state == TX_IDLE) ? w_accept : w_tick;
  assign w_in_nm1   = (clk_per_baud == '0) ? '0 : clk_per_baud - 1'b1;
  assign w_load_val = w_accept ? w_in_nm1 : r_nm1;
  assign w_stop_n   = r_stop2 ? BCW'(2) : BCW'(1);

  baud_tick_counter #(.W(BAUD_WIDTH)) u_baud (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_adv),
    .i_load_val (w_load_val),
    .i_en       (r_state != TX_IDLE),
    .o_tick     (w_tick),
    .o_count    (w_count)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_txd_nxt     = r_txd;
    if (w_adv) begin
      case (r_state)
        TX_IDLE: begin
          w_state_nxt = TX_START;
          w_shift_nxt = tx_data;
          w_txd_nxt   = START_LEVEL;
        end
        TX_START: begin
          w_state_nxt   = TX_DATA;
          w_txd_nxt     = r_shift[0];
          w_shift_nxt   = r_shift >> 1;
          w_bit_cnt_nxt = BCW'(1);
        end
        TX_DATA: begin
          if (r_bit_cnt == BCW'(DATA_WIDTH)) begin
            if (r_par_en) begin
              w_state_nxt = TX_PARITY;
              w_txd_nxt   = r_parity;
            end else begin
              w_state_nxt   = TX_STOP;
              w_txd_nxt     = LINE_IDLE;
              w_bit_cnt_nxt = BCW'(1);
            end
          end else begin
            w_txd_nxt     = r_shift[0];
            w_shift_nxt   = r_shift >> 1;
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
        TX_PARITY: begin
          w_state_nxt   = TX_STOP;
          w_txd_nxt     = LINE_IDLE;
          w_bit_cnt_nxt = BCW'(1);
        end
        TX_STOP: begin
          // The last stop bit may chain straight into the next start bit.
          if (r_bit_cnt == w_stop_n) begin
            if (w_accept) begin
              w_state_nxt = TX_START;
              w_shift_nxt = tx_data;
              w_txd_nxt   = START_LEVEL;
            end else begin
              w_state_nxt = TX_IDLE;
              w_txd_nxt   = LINE_IDLE;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = TX_IDLE;
          w_txd_nxt   = LINE_IDLE;
        end
      endcase
    end
  end

  // Predict next cycle's tick so tx_ready can be registered yet still line up
  // with the final clock of the last stop bit.
  always_comb begin
    w_tick_nxt = w_tick;
    if (w_adv) begin
      w_tick_nxt = (w_load_val == '0);
    end else if ((r_state != TX_IDLE) && (w_count != '0)) begin
      w_tick_nxt = (w_count == BAUD_WIDTH'(1));
    end
    w_ready_nxt = (w_state_nxt == TX_IDLE) ||
                  ((w_state_nxt == TX_STOP) && (w_bit_cnt_nxt == w_stop_n) && w_tick_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= TX_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_nm1     <= '0;
      r_par_en  <= 1'b0;
      r_parity  <= 1'b0;
      r_stop2   <= 1'b0;
      r_txd     <= LINE_IDLE;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_txd     <= w_txd_nxt;
      r_ready   <= w_ready_nxt;
      r_busy    <= (w_state_nxt != TX_IDLE);
      if (w_accept) begin
        r_nm1    <= w_in_nm1;
        r_par_en <= parity_en;
        r_parity <= (^tx_data) ^ parity_odd;
        r_stop2  <= stop_2;
      end
    end
  end

  assign tx_ready  = r_ready;
  assign tx_busy   = r_busy;
  assign txd       = r_txd;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_multi_sample_transmitter.sv
// Directed bench for multi_sample_transmitter: a per-cycle line-level queue model
// checked every cycle, plus hand-derived frame waveforms and lengths.
module tb_multi_sample_transmitter;
  import ms_serial_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tx_data = 8'h33;
  logic        tx_valid = 1'b1;
  logic        tx_ready, tx_busy, txd;
  logic [15:0] clk_per_baud = 16'd1;
  logic        parity_en = 1'b0, parity_odd = 1'b0, stop_2 = 1'b0;
  tx_state_t   dbg_state;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  multi_sample_transmitter #(.BAUD_WIDTH(16), .DATA_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_busy      (tx_busy),
    .txd          (txd),
    .clk_per_baud (clk_per_baud),
    .parity_en    (parity_en),
    .parity_odd   (parity_odd),
    .stop_2       (stop_2),
    .dbg_state    (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: one queue entry per clock of line level still to be emitted.
  logic [0:0] exp_q[$];
  logic m_txd = 1'b1, m_ready = 1'b0, m_busy = 1'b0, m_acc = 1'b0;

  task automatic push_frame(input logic [7:0] d, input logic [15:0] n,
                            input logic pe, input logic po, input logic s2);
    logic [0:0] bits[$];
    int reps;
    reps = (n == 16'd0) ? 1 : int'(n);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((^d) ^ po);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[k]) for (int r = 0; r < reps; r++) exp_q.push_back(bits[k]);
  endtask

  always @(posedge clk) begin
    m_acc = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_txd = 1'b1; m_ready = 1'b0; m_busy = 1'b0;
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (tx_valid && m_ready) begin
        m_acc = 1'b1;
        push_frame(tx_data, clk_per_baud, parity_en, parity_odd, stop_2);
      end
      if (exp_q.size() > 0) begin
        m_txd = exp_q[0]; m_busy = 1'b1; m_ready = (exp_q.size() == 1);
      end else begin
        m_txd = 1'b1; m_busy = 1'b0; m_ready = 1'b1;
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_txd", txd, m_txd);
      check("cyc_ready", tx_ready, m_ready);
      check("cyc_busy", tx_busy, m_busy);
      check("cyc_state_idle", dbg_state == TX_IDLE, !m_busy);
    end
  end

  // driver tasks
  logic [0:0] line_q[$];

  task automatic send(input logic [7:0] d, input logic [15:0] n, input logic pe,
                      input logic po, input logic s2, input bit keep);
    int waited;
    @(negedge clk);
    tx_data = d; clk_per_baud = n; parity_en = pe; parity_odd = po; stop_2 = s2;
    tx_valid = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!m_acc && waited < 2000);
    if (!m_acc) check("accept_timeout", 32'd0, 32'd1);
    if (!keep) tx_valid = 1'b0;
  endtask

  // Capture txd for every busy cycle. At index ev_at either change the baud
  // setting (ev_kind 0) or assert reset (ev_kind 1).
  task automatic measure(input int ev_at, input int ev_kind, input logic [15:0] ev_n,
                         output int len, output int acc_at);
    line_q.delete();
    len = 0;
    acc_at = -1;
    while (tx_busy === 1'b1 && len < 5000) begin
      line_q.push_back(txd);
      if (m_acc && len > 0) begin
        tx_valid = 1'b0;
        acc_at = len;
      end
      if (len == ev_at) begin
        if (ev_kind == 0) clk_per_baud = ev_n;
        else rst = 1'b1;
      end
      len++;
      @(negedge clk);
    end
    if (len >= 5000) check("busy_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_bits(input string name, input logic [15:0] lits, input int nbits, input int n);
    for (int b = 0; b < nbits; b++) begin
      if (line_q.size() >= (b + 1) * n) begin
        check($sformatf("%s_b%0d_first", name, b), line_q[b*n], lits[b]);
        check($sformatf("%s_b%0d_last", name, b), line_q[b*n+n-1], lits[b]);
      end
    end
  endtask

  initial begin
    int len, acc_at;

    // 1: reset with tx_valid high
    @(posedge clk);
    cmp_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t1_rst_txd", txd, 1'b1);
      check("t1_rst_ready", tx_ready, 1'b0);
      check("t1_rst_busy", tx_busy, 1'b0);
    end
    rst = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    check("t1_ready_after", tx_ready, 1'b1);
    check("t1_busy_after", tx_busy, 1'b0);

    // 2: 0xA5, N=7, no parity, 1 stop -> 0,1,0,1,0,0,1,0,1,1
    send(8'hA5, 16'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    measure(-1, 0, 16'd0, len, acc_at);
    check("t2_len", len, 70);
    check_bits("t2", 16'b11_0100_1010, 10, 7);

    // 3: 0x07, N=4, even parity, 2 stops -> parity 1; odd -> parity 0
    send(8'h07, 16'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    measure(-1, 0, 16'd0, len, acc_at);
    check("t3e_len", len, 48);
    check_bits("t3e", 16'b1110_0000_1110, 12, 4);
    send(8'h07, 16'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    measure(-1, 0, 16'd0, len, acc_at);
    check("t3o_len", len, 48);
    check_bits("t3o", 16'b1100_0000_1110, 12, 4);

    // 4: back-to-back 0x00 then 0xFF, N=3
    send(8'h00, 16'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    tx_data = 8'hFF;
    measure(-1, 0, 16'd0, len, acc_at);
    check("t4_len", len, 60);
    check("t4_acc_at", acc_at, 30);
    if (line_q.size() >= 60) begin
      check("t4_stop1", line_q[29], 1'b1);
      check("t4_start2", line_q[30], 1'b0);
      check("t4_data2", line_q[33], 1'b1);
      check("t4_stop2", line_q[59], 1'b1);
    end

    // 5: N=0 acts as N=1; baud change mid-frame only hits the next frame
    send(8'h3C, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    measure(-1, 0, 16'd0, len, acc_at);
    check("t5_n0_len", len, 10);
    check_bits("t5_n0", 16'b10_0111_1000, 10, 1);
    send(8'h81, 16'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    measure(20, 0, 16'd2, len, acc_at);
    check("t5_mid_len", len, 70);
    check_bits("t5_mid", 16'b11_0000_0010, 10, 7);
    send(8'h96, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    measure(-1, 0, 16'd0, len, acc_at);
    check("t5_next_len", len, 20);
    check_bits("t5_next", 16'b11_0010_1100, 10, 2);

    // 6: reset during data bit 3 of 0x5A (N=4: cycles 16..19)
    send(8'h5A, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    measure(17, 1, 16'd0, len, acc_at);
    check("t6_abort_len", len, 18);
    check("t6_rst_txd", txd, 1'b1);
    check("t6_rst_ready", tx_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("t6_ready_after", tx_ready, 1'b1);
    send(8'h5A, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    measure(-1, 0, 16'd0, len, acc_at);
    check("t6_len", len, 40);
    check_bits("t6", 16'b10_1011_0100, 10, 4);

    repeat (3) @(negedge clk);
    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
